multichannel_frame_assembler: RTL and testbench

//  Successor to the stereo demux buffer: collects per-channel samples tagged with a channel index into N-channel frames.

---
 rtl/multichannel_frame_assembler_pkg.sv | 17 +
 rtl/multichannel_frame_assembler_if.sv | 29 ++
 rtl/multichannel_frame_assembler_fifo.sv | 50 +++++
 rtl/multichannel_frame_assembler.sv | 127 ++++++++++++
 tb/tb_multichannel_frame_assembler.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/multichannel_frame_assembler_pkg.sv
// Shared audio types: default sample width, channel index type, named
// channels and a default two-channel frame layout (channel k in slice k).
package ovdp_audio_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int NUM_CH_DEF = 2;
  localparam int CH_W_DEF   = $clog2(NUM_CH_DEF);

  typedef logic [CH_W_DEF-1:0] ch_idx_t;

  localparam ch_idx_t CH_LEFT  = ch_idx_t'(0);
  localparam ch_idx_t CH_RIGHT = ch_idx_t'(1);

  typedef logic signed [DATA_W_DEF-1:0] sample_t;
  typedef sample_t [NUM_CH_DEF-1:0]     frame_t;

endpackage

// File: rtl/multichannel_frame_assembler_if.sv
// Sample-in / frame-out bundle of the frame assembler. The slave modport is
// the assembler's view; the master modport is the surrounding system's view.
interface multichannel_frame_assembler_if #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 16
);
  localparam int CH_W = $clog2(NUM_CH);

  logic signed [DATA_W-1:0]  sample_in;
  logic [CH_W-1:0]           ch_in;
  logic                      valid_in;
  logic [NUM_CH*DATA_W-1:0]  frame_data;
  logic                      frame_valid;
  logic                      frame_ready;
  logic                      dup_err;
  logic                      ch_err;
  logic                      ovf_err;
  logic [15:0]               drop_count;

  modport master (
    output sample_in, ch_in, valid_in, frame_ready,
    input  frame_data, frame_valid, dup_err, ch_err, ovf_err, drop_count
  );

  modport slave (
    input  sample_in, ch_in, valid_in, frame_ready,
    output frame_data, frame_valid, dup_err, ch_err, ovf_err, drop_count
  );
endinterface

// File: rtl/multichannel_frame_assembler_fifo.sv
// Synchronous frame FIFO. Pointers carry an extra MSB to tell full from
// empty. The head word is read straight from the array so a frame is visible
// the cycle after it is written; the head reads as zero while empty.
module frame_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop_ok  = i_pop && !o_empty;
  // A pop frees the head slot on the same edge, so full-with-pop still accepts.
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  // Storage write; contents need no reset because empty masks the head.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

  // Pointer update; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/multichannel_frame_assembler.sv
// Multichannel frame assembler: gathers channel-tagged samples into frames of
// one sample per channel and queues complete frames for a valid/ready sink.
// Optional feature macro FRAME_TIMEOUT_EN: discard a partial frame that sees
// no accepted sample for TIMEOUT_CYC cycles (reported on ch_err).
module multichannel_frame_assembler
  import ovdp_audio_pkg::*;
#(
  parameter int NUM_CH     = NUM_CH_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 4
`ifdef FRAME_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 4096
`endif
) (
  input logic                         clk,
  input logic                         reset,
  multichannel_frame_assembler_if.slave bus
);
  logic [NUM_CH-1:0][DATA_W-1:0] r_stage;
  logic [NUM_CH-1:0]             r_mask;
  logic                          r_dup_err;
  logic                          r_ch_err;
  logic                          r_ovf_err;
  logic [15:0]                   r_drop_count;

  logic [NUM_CH-1:0]             w_hit;
  logic [NUM_CH-1:0][DATA_W-1:0] w_frame;
  logic                          w_accept;
  logic                          w_illegal;
  logic                          w_dup;
  logic                          w_complete;
  logic                          w_timeout;
  logic                          w_pop;
  logic                          w_full;
  logic                          w_empty;
  logic [NUM_CH*DATA_W-1:0]      w_head;

  // Per-channel decode; the outgoing frame is staging with the live sample
  // substituted so the completing sample travels with its own frame.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign w_hit[gi]   = bus.valid_in && (int'(bus.ch_in) == gi);
    assign w_frame[gi] = w_hit[gi] ? bus.sample_in : r_stage[gi];
  end

  assign w_accept   = |w_hit;
  assign w_illegal  = bus.valid_in && !w_accept;
  assign w_dup      = |(w_hit & r_mask);
  assign w_complete = w_accept && ((r_mask | w_hit) == '1);
  assign w_pop      = !w_empty && bus.frame_ready;

`ifdef FRAME_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC) + 1;
  logic [TO_W-1:0] r_to_cnt;

  assign w_timeout = (r_mask != '0) && !w_accept &&
                     (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

  // Idle-cycle counter for a partial frame; any accepted sample restarts it.
  always_ff @(posedge clk) begin
    if (reset || w_accept || (r_mask == '0) || w_timeout) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Staging and fill mask; completion or timeout clears the mask.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stage <= '0;
      r_mask  <= '0;
    end else begin
      if (w_timeout) begin
        r_stage <= '0;
      end else if (w_accept) begin
        r_stage <= w_frame;
      end
      if (w_complete || w_timeout) begin
        r_mask <= '0;
      end else begin
        r_mask <= r_mask | w_hit;
      end
    end
  end

  // Registered one-cycle error pulses and saturating dropped-frame count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dup_err    <= 1'b0;
      r_ch_err     <= 1'b0;
      r_ovf_err    <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_dup_err <= w_dup;
      r_ch_err  <= w_illegal || w_timeout;
      r_ovf_err <= w_complete && w_full && !w_pop;
      if (w_complete && w_full && !w_pop && (r_drop_count != 16'hFFFF)) begin
        r_drop_count <= r_drop_count + 16'd1;
      end
    end
  end

  frame_fifo #(
    .WIDTH (NUM_CH*DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_complete),
    .i_data  (w_frame),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.frame_data  = w_head;
  assign bus.frame_valid = !w_empty;
  assign bus.dup_err     = r_dup_err;
  assign bus.ch_err      = r_ch_err;
  assign bus.ovf_err     = r_ovf_err;
  assign bus.drop_count  = r_drop_count;
endmodule

// File: tb/tb_multichannel_frame_assembler.sv
// Bench for multichannel_frame_assembler: a 2-channel instance driven from a
// vector table with a frame scoreboard, and a 3-channel instance for the
// illegal-index and mid-frame reset sequences.
module tb_multichannel_frame_assembler;
  import ovdp_audio_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_dup = 0;
  int n_cherr = 0;
  int n_ovf = 0;
  logic [31:0] exp_q [$];

  multichannel_frame_assembler_if #(.NUM_CH(2), .DATA_W(16)) bus2 ();
  multichannel_frame_assembler_if #(.NUM_CH(3), .DATA_W(16)) bus3 ();

  multichannel_frame_assembler #(
    .NUM_CH(2), .DATA_W(16), .FIFO_DEPTH(4)
`ifdef FRAME_TIMEOUT_EN
    , .TIMEOUT_CYC(8)
`endif
  ) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  multichannel_frame_assembler #(
    .NUM_CH(3), .DATA_W(16), .FIFO_DEPTH(4)
`ifdef FRAME_TIMEOUT_EN
    , .TIMEOUT_CYC(8)
`endif
  ) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  typedef struct {
    ch_idx_t     ch;
    logic [15:0] data;
    logic        exp_dup;
    logic        exp_done;
    logic [31:0] exp_frame;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic send2(input ch_idx_t ch, input logic [15:0] d);
    bus2.valid_in  = 1'b1;
    bus2.ch_in     = ch;
    bus2.sample_in = d;
    @(posedge clk); #1;
    bus2.valid_in  = 1'b0;
  endtask

  task automatic send3(input logic [1:0] ch, input logic [15:0] d);
    bus3.valid_in  = 1'b1;
    bus3.ch_in     = ch;
    bus3.sample_in = d;
    @(posedge clk); #1;
    bus3.valid_in  = 1'b0;
  endtask

  // Scoreboard: compare each frame of the 2-channel instance as it is taken.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus2.dup_err) n_dup++;
      if (bus2.ch_err)  n_cherr++;
      if (bus2.ovf_err) n_ovf++;
      if (bus2.frame_valid && bus2.frame_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_frame", 64'(bus2.frame_data), 64'hDEAD);
        end else begin
          $display("frame out %h (expected %h)", bus2.frame_data, exp_q[0]);
          check("frame_data", 64'(bus2.frame_data), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    logic [15:0] b;
    int ovf0;
    int ce0;
    int hit;

    bus2.valid_in = 1'b0; bus2.ch_in = '0; bus2.sample_in = '0; bus2.frame_ready = 1'b1;
    bus3.valid_in = 1'b0; bus3.ch_in = '0; bus3.sample_in = '0; bus3.frame_ready = 1'b1;

    vecs[0]  = '{CH_LEFT,  16'h1234, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{CH_RIGHT, 16'hABCD, 1'b0, 1'b1, 32'hABCD_1234};
    vecs[2]  = '{CH_RIGHT, 16'h0005, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{CH_LEFT,  16'h0007, 1'b0, 1'b1, 32'h0005_0007};
    vecs[4]  = '{CH_LEFT,  16'h0011, 1'b0, 1'b0, 32'h0};
    vecs[5]  = '{CH_RIGHT, 16'h0022, 1'b0, 1'b1, 32'h0022_0011};
    vecs[6]  = '{CH_LEFT,  16'h0001, 1'b0, 1'b0, 32'h0};
    vecs[7]  = '{CH_LEFT,  16'h0002, 1'b1, 1'b0, 32'h0};
    vecs[8]  = '{CH_RIGHT, 16'h0003, 1'b0, 1'b1, 32'h0003_0002};
    vecs[9]  = '{CH_RIGHT, 16'h8000, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{CH_LEFT,  16'hFFFF, 1'b0, 1'b1, 32'h8000_FFFF};

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_valid2", 64'(bus2.frame_valid), 0);
    check("rst_data2",  64'(bus2.frame_data), 0);
    check("rst_errs2",  64'({bus2.dup_err, bus2.ch_err, bus2.ovf_err}), 0);
    check("rst_drop2",  64'(bus2.drop_count), 0);
    check("rst_valid3", 64'(bus3.frame_valid), 0);
    check("rst_data3",  64'(bus3.frame_data), 0);

    // Table-driven assembly, latency and duplicate checks
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].exp_done) exp_q.push_back(vecs[i].exp_frame);
      send2(vecs[i].ch, vecs[i].data);
      $display("vec %0d ch=%0d data=%h dup=%b valid=%b", i, vecs[i].ch, vecs[i].data,
               bus2.dup_err, bus2.frame_valid);
      check("dup_err", 64'(bus2.dup_err), 64'(vecs[i].exp_dup));
      check("frame_valid_latency", 64'(bus2.frame_valid), 64'(vecs[i].exp_done));
    end
    @(posedge clk); #1;
    check("table_frames_all_out", 64'(exp_q.size()), 0);
    check("table_dup_pulses", 64'(n_dup), 1);

    // Backpressure: five frames into a four-deep FIFO, fifth dropped
    bus2.frame_ready = 1'b0;
    ovf0 = n_ovf;
    for (int k = 0; k < 5; k++) begin
      a = 16'h0100 + 16'(k);
      b = 16'h0200 + 16'(k);
      if (k < 4) exp_q.push_back({b, a});
      send2(CH_LEFT, a);
      send2(CH_RIGHT, b);
      $display("stall frame %0d ovf=%b drop=%0d", k, bus2.ovf_err, bus2.drop_count);
      check("ovf_err", 64'(bus2.ovf_err), 64'(k == 4));
    end
    check("drop_count_1", 64'(bus2.drop_count), 1);
    check("head_stable", 64'(bus2.frame_data), 64'h0200_0100);
    @(posedge clk); #1;
    check("ovf_single_pulse", 64'(n_ovf - ovf0), 1);
    check("head_still_valid", 64'(bus2.frame_valid), 1);
    bus2.frame_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
    #1;
    check("drain_4_frames", 64'(exp_q.size()), 0);
    check("empty_after_drain", 64'(bus2.frame_valid), 0);

    // Full FIFO with a pop on the completing edge accepts the new frame
    bus2.frame_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      a = 16'h0300 + 16'(k);
      b = 16'h0400 + 16'(k);
      exp_q.push_back({b, a});
      send2(CH_LEFT, a);
      send2(CH_RIGHT, b);
    end
    send2(CH_LEFT, 16'h0305);
    bus2.frame_ready = 1'b1;
    exp_q.push_back(32'h0405_0305);
    send2(CH_RIGHT, 16'h0405);
    $display("full+pop push ovf=%b drop=%0d", bus2.ovf_err, bus2.drop_count);
    check("full_pop_no_ovf", 64'(bus2.ovf_err), 0);
    check("full_pop_drop_same", 64'(bus2.drop_count), 1);
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
    #1;
    check("drain_5_frames", 64'(exp_q.size()), 0);

    // Partial-frame timeout (or indefinite hold when the feature is off)
    ce0 = n_cherr;
    hit = 0;
    send2(CH_LEFT, 16'h0AAA);
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (bus2.ch_err && hit == 0) hit = c;
    end
    $display("idle partial frame: ch_err after %0d cycles", hit);
`ifdef FRAME_TIMEOUT_EN
    check("timeout_cycles", 64'(hit), 8);
    check("timeout_pulses", 64'(n_cherr - ce0), 1);
    send2(CH_LEFT, 16'h0CCC);
    check("after_timeout_no_dup", 64'(bus2.dup_err), 0);
    check("after_timeout_partial", 64'(bus2.frame_valid), 0);
    exp_q.push_back(32'h0DDD_0CCC);
    send2(CH_RIGHT, 16'h0DDD);
    check("after_timeout_frame", 64'(bus2.frame_valid), 1);
`else
    check("no_timeout", 64'(hit), 0);
    exp_q.push_back(32'h0BBB_0AAA);
    send2(CH_RIGHT, 16'h0BBB);
    check("held_partial_completes", 64'(bus2.frame_valid), 1);
`endif
    @(posedge clk); #1;
    check("timeout_frames_out", 64'(exp_q.size()), 0);

    // Three channels: illegal index ignored, state kept
    send3(2'd0, 16'h0A0A);
    check("ch3_no_err", 64'(bus3.ch_err), 0);
    send3(2'd3, 16'h7777);
    $display("illegal ch=3 ch_err=%b", bus3.ch_err);
    check("ch3_illegal_err", 64'(bus3.ch_err), 1);
    check("ch3_illegal_no_frame", 64'(bus3.frame_valid), 0);
    send3(2'd1, 16'h0B0B);
    check("ch3_err_one_cycle", 64'(bus3.ch_err), 0);
    check("ch3_no_dup", 64'(bus3.dup_err), 0);
    send3(2'd2, 16'h0C0C);
    $display("ch3 frame %h", bus3.frame_data);
    check("ch3_frame_valid", 64'(bus3.frame_valid), 1);
    check("ch3_frame_data", 64'(bus3.frame_data), 64'h0C0C_0B0B_0A0A);
    @(posedge clk); #1;

    // Reset mid-frame discards the partial frame
    send3(2'd0, 16'h5555);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_mid_valid3", 64'(bus3.frame_valid), 0);
    check("rst_mid_drop2", 64'(bus2.drop_count), 0);
    send3(2'd1, 16'h6666);
    send3(2'd2, 16'h7777);
    check("rst_mask_cleared", 64'(bus3.frame_valid), 0);
    send3(2'd0, 16'h8888);
    $display("post-reset ch3 frame %h", bus3.frame_data);
    check("rst_then_frame_valid", 64'(bus3.frame_valid), 1);
    check("rst_then_frame_data", 64'(bus3.frame_data), 64'h7777_6666_8888);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
